my_pe_mac: RTL and testbench
============================

# my_pe_mac

Single-precision floating-point multiply-accumulate processing element with a private local operand buffer. A host first loads 2^L_RAM_SIZE 32-bit words into the buffer via `din`/`we`. It then issues MAC requests: each request multiplies `ain` by `buffer[addr]` and adds the product to an internal running sum. The block is the leaf compute unit of the matrix/vector datapath, and `dout` carries the running sum.

## Interface
- `L_RAM_SIZE`, default 4: address width; the buffer holds 2^L_RAM_SIZE words of 32 bits.

- `aclk` input 1: clock; all logic on the rising edge.
- `aresetn` input 1: reset, asynchronous and active-high (asserted when 1). One clock; reset is asynchronous and active-high.
- `ain` input 32: FP32 multiplicand; sampled with `valid`.
- `din` input 32: FP32 word written to the buffer when `we`=1.
- `addr` input L_RAM_SIZE: buffer address for both write and MAC read.
- `we` input 1: buffer write enable.
- `valid` input 1: MAC request strobe.
- `dvalid` output 1: one-cycle pulse; `dout` was just updated.
- `dout` output 32: FP32 accumulator value.

## Operation
- **Buffer**
  - 2^L_RAM_SIZE × 32 registers.
  - At every rising edge with `we`=1: `buffer[addr] <= din`.
  - Reset does not clear the buffer.
- **MAC request**
  - Accepted at a rising edge with `valid`=1 while the block is idle.
  - On acceptance, capture `ain` and `buffer[addr]` (the contents before any same-edge write, i.e. read-before-write).
  - Compute `acc <= acc + ain*buffer[addr]`.
- **Arithmetic**
  - IEEE-754 binary32.
  - Multiply rounded to nearest-even, then add rounded to nearest-even; not fused.
  - Subnormal inputs and results flush to +0.
  - Overflow produces ±Inf.
  - Any NaN operand, Inf×0, or Inf−Inf produces 0x7FC00000.
  - An exact zero sum produces +0.
- **Accumulator**
  - `acc` resets to 0x00000000.
  - Cleared only by reset.
  - `dout` = `acc` at all times.
- **States**
  - IDLE: accept `valid`, go to BUSY.
  - BUSY: a 4-stage pipeline runs; on completion update `acc`, pulse `dvalid`, return to IDLE.
- **`valid` while BUSY** is ignored entirely: no queueing, no effect on `acc`.
- **`we` while BUSY** is allowed. It does not affect the in-flight operand, which was already captured.

## Timing
- `valid` sampled at edge N produces the new `dout` and `dvalid`=1 at edge N+4 (latency 4 cycles).
- `dvalid` is high for exactly one cycle (N+4 to N+5).
- The earliest next accepted `valid` is at edge N+4, the same edge `dvalid` rises; the block is IDLE from that edge.
  - Back-to-back requests therefore have a throughput of 1 per 4 cycles.
  - The next request sees the updated `acc`.
- `dout` is registered and holds its value between updates.
- Buffer write takes effect at the sampling edge; a MAC request at edge N+1 reads the word written at edge N.
- **Reset**
  - `dvalid`=0 and `dout`=0x00000000 immediately, asynchronously.
  - Any in-flight operation is discarded; the state returns to IDLE.
  - The first edge after deassertion can accept `valid`.

## Test plan
- **Load and single MAC:** write 0x3F800000 (1.0) to addr 0; `valid` with `ain`=0x40000000 (2.0), `addr`=0 -> `dvalid` pulse 4 cycles later, `dout`=0x40000000.
- **Accumulate:** continuing, write 0x40400000 (3.0) to addr 1; `ain`=0x3F000000 (0.5), `addr`=1 -> `dout`=0x40600000 (3.5).
- **Cancellation and zero:** continuing, `ain`=0xC0600000 (−3.5), `addr`=0 (1.0) -> `dout`=0x00000000.
- **Full sweep:** load all 16 entries with din[i]=i (as FP32); issue 16 sequential requests with `ain`=1.0, `addr`=0..15, each request issued after the previous `dvalid` -> 16 `dvalid` pulses; final `dout`=0x42F00000 (120.0).
- **Busy rejection:** assert `valid` at N, N+1 and N+2 -> only one `dvalid`, at N+4, with one product added. **Read-before-write:** `we` and `valid` on the same edge -> the MAC uses the old word.
- **Reset mid-operation:** assert `aresetn`=1 at N+2 of a request -> `dout`=0 and `dvalid`=0 immediately; no `dvalid` afterward; the buffer contents survive.

Source files
------------

// File: rtl/my_pe_mac.sv
// my_pe_mac -- FP32 multiply-accumulate processing element with a private
// operand buffer.
//
// The host loads the buffer through din/we/addr, then issues MAC requests.
// Each accepted request computes acc <= acc + ain * buffer[addr] using
// binary32 arithmetic (multiply rounded, then add rounded; not fused).
//
// Request handshake: a request is taken at a rising edge where valid=1 and
// the block can accept (IDLE, or the write-back cycle of the previous
// request). There is no ready signal; valid at any other edge is dropped
// without effect. dvalid pulses for one cycle when dout has been updated.
//
// Ports:
//   aclk        clock, rising edge
//   aresetn     asynchronous reset, active-high
//   ain         FP32 multiplicand, sampled with valid
//   din         FP32 word written to buffer[addr] when we=1
//   addr        buffer address for writes and MAC reads
//   we          buffer write enable
//   valid       MAC request strobe
//   dvalid      one-cycle pulse: dout was just updated
//   dout        FP32 accumulator
//   dbg_state_o current FSM state, for observation only
module my_pe_mac #(
    parameter int L_RAM_SIZE = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [31:0]           ain,
    input  logic [31:0]           din,
    input  logic [L_RAM_SIZE-1:0] addr,
    input  logic                  we,
    input  logic                  valid,
    output logic                  dvalid,
    output logic [31:0]           dout,
    output logic [2:0]            dbg_state_o
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_ADD  = 3'd2,
        S_HOLD = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        dvalid_q, dvalid_d;
    logic [31:0] acc_q;
    logic [31:0] op_a_q, op_b_q;
    logic [31:0] prod_q, prod_d;
    logic [31:0] sum_q, sum_d;
    logic        accept;
    logic        commit;

    logic [31:0] buf_q [2**L_RAM_SIZE];

    // ------------------------------------------------------------------
    // FP32 multiply, round to nearest-even, subnormals flushed to +0.
    // ------------------------------------------------------------------
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic              sr, rb, st, inc;
        logic [47:0]       p;
        logic [23:0]       m;
        logic [24:0]       mr;
        logic signed [9:0] e;
        logic [31:0]       res;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        sr     = a[31] ^ b[31];
        p      = 48'd0;
        m      = 24'd0;
        mr     = 25'd0;
        rb     = 1'b0;
        st     = 1'b0;
        inc    = 1'b0;
        e      = 10'sd0;
        res    = 32'd0;
        if (a_nan || b_nan) begin
            res = QNAN;
        end else if (a_inf || b_inf) begin
            res = (a_zero || b_zero) ? QNAN : {sr, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            res = 32'd0;
        end else begin
            p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
            e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
            // Product of two 1.x mantissas lies in [1,4); pick the window
            // holding the leading one and keep round/sticky below it.
            if (p[47]) begin
                m  = p[47:24];
                rb = p[23];
                st = |p[22:0];
                e  = e + 10'sd1;
            end else begin
                m  = p[46:23];
                rb = p[22];
                st = |p[21:0];
            end
            inc = rb & (st | m[0]);
            mr  = {1'b0, m} + {24'd0, inc};
            if (mr[24]) begin
                mr = mr >> 1;
                e  = e + 10'sd1;
            end
            if (e >= 10'sd255)     res = {sr, 8'hFF, 23'd0};
            else if (e <= 10'sd0)  res = 32'd0;
            else                   res = {sr, e[7:0], mr[22:0]};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // FP32 add, round to nearest-even, subnormals flushed to +0, exact
    // zero sums give +0. Guard/round/sticky are carried in the low three
    // bits of the 27-bit working mantissa.
    // ------------------------------------------------------------------
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [31:0]       x, y, res;
        logic [7:0]        d;
        logic [26:0]       mx, my, my_sh, n;
        logic [27:0]       s28;
        logic              lost, g, st, inc, found;
        logic [4:0]        lz;
        logic [24:0]       mr;
        logic signed [9:0] e;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        x      = a;
        y      = b;
        d      = 8'd0;
        mx     = 27'd0;
        my     = 27'd0;
        my_sh  = 27'd0;
        n      = 27'd0;
        s28    = 28'd0;
        lost   = 1'b0;
        g      = 1'b0;
        st     = 1'b0;
        inc    = 1'b0;
        found  = 1'b0;
        lz     = 5'd0;
        mr     = 25'd0;
        e      = 10'sd0;
        res    = 32'd0;
        if (a_nan || b_nan) begin
            res = QNAN;
        end else if (a_inf && b_inf) begin
            res = (a[31] != b[31]) ? QNAN : a;
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = b;
        end else if (a_zero && b_zero) begin
            res = 32'd0;
        end else if (a_zero) begin
            res = b;
        end else if (b_zero) begin
            res = a;
        end else begin
            // x carries the larger magnitude and hence the result sign.
            if (b[30:0] > a[30:0]) begin
                x = b;
                y = a;
            end
            d  = x[30:23] - y[30:23];
            mx = {1'b1, x[22:0], 3'b000};
            my = {1'b1, y[22:0], 3'b000};
            if (d >= 8'd27) begin
                my_sh = 27'd1;
            end else begin
                my_sh    = my >> d;
                lost     = |(my & ((27'd1 << d) - 27'd1));
                my_sh[0] = my_sh[0] | lost;
            end
            e = $signed({2'b00, x[30:23]});
            if (x[31] == y[31]) begin
                s28 = {1'b0, mx} + {1'b0, my_sh};
                if (s28[27]) begin
                    n = {s28[27:2], s28[1] | s28[0]};
                    e = e + 10'sd1;
                end else begin
                    n = s28[26:0];
                end
            end else begin
                n = mx - my_sh;
            end
            if (n == 27'd0) begin
                res = 32'd0;
            end else begin
                for (int i = 26; i >= 0; i--) begin
                    if (!found) begin
                        if (n[i]) found = 1'b1;
                        else      lz = lz + 5'd1;
                    end
                end
                n   = n << lz;
                e   = e - $signed({5'b00000, lz});
                g   = n[2];
                st  = n[1] | n[0];
                inc = g & (st | n[3]);
                mr  = {1'b0, n[26:3]} + {24'd0, inc};
                if (mr[24]) begin
                    mr = mr >> 1;
                    e  = e + 10'sd1;
                end
                if (e >= 10'sd255)     res = {x[31], 8'hFF, 23'd0};
                else if (e <= 10'sd0)  res = 32'd0;
                else                   res = {x[31], e[7:0], mr[22:0]};
            end
        end
        return res;
    endfunction

    // Operand buffer: not reset, written on any edge with we=1.
    always_ff @(posedge aclk) begin
        if (we) buf_q[addr] <= din;
    end

    // FSM next state. The write-back cycle can also accept, which gives
    // one request per four cycles when valid is held high.
    always_comb begin
        state_d  = state_q;
        dvalid_d = 1'b0;
        accept   = 1'b0;
        commit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    accept  = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_MUL:  state_d = S_ADD;
            S_ADD:  state_d = S_HOLD;
            // S_HOLD pads the pipeline to its fixed four-cycle latency.
            S_HOLD: state_d = S_WB;
            S_WB: begin
                commit   = 1'b1;
                dvalid_d = 1'b1;
                if (valid) begin
                    accept  = 1'b1;
                    state_d = S_MUL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The add reads acc_q two cycles after capture, so a request accepted
    // in the write-back cycle sees the freshly committed sum.
    always_comb begin
        prod_d = fp_mul(op_a_q, op_b_q);
        sum_d  = fp_add(acc_q, prod_q);
    end

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            state_q  <= S_IDLE;
            dvalid_q <= 1'b0;
            acc_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            dvalid_q <= dvalid_d;
            if (commit) acc_q <= sum_q;
        end
    end

    // Pipeline operands; contents are meaningless outside an operation,
    // so they need no reset.
    always_ff @(posedge aclk) begin
        if (accept) begin
            op_a_q <= ain;
            op_b_q <= buf_q[addr];
        end
        if (state_q == S_MUL) prod_q <= prod_d;
        if (state_q == S_ADD) sum_q  <= sum_d;
    end

    assign dvalid      = dvalid_q;
    assign dout        = acc_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_my_pe_mac.sv
module tb_my_pe_mac;

  localparam int L = 4;
  localparam int N = 16;

  // ---------------- clock / reset ----------------
  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic [31:0]   ain = '0;
  logic [31:0]   din = '0;
  logic [L-1:0]  addr = '0;
  logic          we = 1'b0;
  logic          valid = 1'b0;
  logic          dvalid;
  logic [31:0]   dout;
  logic [2:0]    dbg_state;

  always #5 aclk = ~aclk;

  my_pe_mac #(.L_RAM_SIZE(L)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .ain         (ain),
    .din         (din),
    .addr        (addr),
    .we          (we),
    .valid       (valid),
    .dvalid      (dvalid),
    .dout        (dout),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pop;
  int          acc_m;
  int          bufm[N];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Exact FP32 encoding of a small integer (|v| < 2^24).
  function automatic logic [31:0] int_to_fp(input int v);
    logic [31:0] mag;
    logic [31:0] r;
    int          p;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'(mag << (23 - p));
    return r;
  endfunction

  // Output monitor: every dvalid pulse pops one expected sum.
  always @(negedge aclk) begin
    if (dvalid) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_dvalid", 32'(dvalid), 32'h0);
      end else begin
        exp_pop = exp_q.pop_front();
        check_val("dout", dout, exp_pop);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input int a, input logic [31:0] d);
    @(negedge aclk);
    we   = 1'b1;
    addr = a[L-1:0];
    din  = d;
    @(posedge aclk);
    #1 we = 1'b0;
  endtask

  task automatic mac(input logic [31:0] a, input int ad, input logic [31:0] e);
    int k;
    @(negedge aclk);
    ain   = a;
    addr  = ad[L-1:0];
    valid = 1'b1;
    exp_q.push_back(e);
    @(posedge aclk);
    #1 valid = 1'b0;
    k = 0;
    while (k < 8 && !dvalid) begin
      @(posedge aclk);
      #1;
      k++;
    end
    check_val("latency", 32'(k), 32'd4);
    @(negedge aclk);
    #1;
  endtask

  task automatic mac_int(input int a, input int ad);
    acc_m = acc_m + a * bufm[ad];
    mac(int_to_fp(a), ad, int_to_fp(acc_m));
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) @(posedge aclk);
    @(negedge aclk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a, v, x;
    acc_m = 0;
    for (int i = 0; i < N; i++) bufm[i] = 0;

    #12;
    check_val("reset_dout", dout, 32'h0);
    check_val("reset_dvalid", 32'(dvalid), 32'h0);
    check_val("reset_state", 32'(dbg_state), 32'h0);
    @(negedge aclk);
    aresetn = 1'b0;

    // Load, single MAC, accumulate, cancellation.
    wr(0, 32'h3F800000);
    mac(32'h40000000, 0, 32'h40000000);
    wr(1, 32'h40400000);
    mac(32'h3F000000, 1, 32'h40600000);
    mac(32'hC0600000, 0, 32'h00000000);
    check_val("cancel_zero", dout, 32'h0);
    acc_m = 0;

    // Full sweep: buffer[i] = i, ain = 1.0.
    for (int i = 0; i < N; i++) begin
      wr(i, int_to_fp(i));
      bufm[i] = i;
    end
    for (int i = 0; i < N; i++) mac_int(1, i);
    check_val("sweep_final", dout, 32'h42F00000);

    // Random small-integer traffic (all results exactly representable).
    for (int i = 0; i < 10; i++) begin
      a = int'($urandom_range(0, N - 1));
      v = int'($urandom_range(0, 40)) - 20;
      wr(a, int_to_fp(v));
      bufm[a] = v;
      x = int'($urandom_range(0, 40)) - 20;
      mac_int(x, int'($urandom_range(0, N - 1)));
    end

    // Busy rejection: valid high on three consecutive edges -> one result.
    wr(2, int_to_fp(6));
    bufm[2] = 6;
    @(negedge aclk);
    ain   = int_to_fp(3);
    addr  = 4'd2;
    valid = 1'b1;
    acc_m = acc_m + 3 * bufm[2];
    exp_q.push_back(int_to_fp(acc_m));
    repeat (3) @(posedge aclk);
    #1 valid = 1'b0;
    settle(8);
    check_val("busy_queue_empty", 32'(exp_q.size()), 32'h0);

    // Valid held for five edges -> accepted at N and N+4, second sees update.
    @(negedge aclk);
    ain   = int_to_fp(-2);
    addr  = 4'd2;
    valid = 1'b1;
    acc_m = acc_m - 2 * bufm[2];
    exp_q.push_back(int_to_fp(acc_m));
    acc_m = acc_m - 2 * bufm[2];
    exp_q.push_back(int_to_fp(acc_m));
    repeat (5) @(posedge aclk);
    #1 valid = 1'b0;
    settle(10);
    check_val("b2b_queue_empty", 32'(exp_q.size()), 32'h0);

    // Read-before-write on the same edge.
    wr(3, int_to_fp(4));
    bufm[3] = 4;
    @(negedge aclk);
    we    = 1'b1;
    din   = int_to_fp(9);
    ain   = int_to_fp(2);
    addr  = 4'd3;
    valid = 1'b1;
    acc_m = acc_m + 2 * bufm[3];
    exp_q.push_back(int_to_fp(acc_m));
    bufm[3] = 9;
    @(posedge aclk);
    #1;
    we    = 1'b0;
    valid = 1'b0;
    settle(8);
    check_val("rbw_queue_empty", 32'(exp_q.size()), 32'h0);
    mac_int(1, 3);

    // Overflow, Inf propagation, Inf - Inf, NaN stickiness.
    wr(5, int_to_fp(7));
    bufm[5] = 7;
    wr(2, 32'h7F000000);
    mac(32'h40000000, 2, 32'h7F800000);
    mac(32'h3F800000, 5, 32'h7F800000);
    mac(32'hFF800000, 5, 32'h7FC00000);
    mac(32'h3F800000, 5, 32'h7FC00000);

    // Reset in the middle of an operation.
    @(negedge aclk);
    ain   = int_to_fp(1);
    addr  = 4'd5;
    valid = 1'b1;
    @(posedge aclk);
    #1 valid = 1'b0;
    @(posedge aclk);
    @(posedge aclk);
    #2 aresetn = 1'b1;
    #1;
    check_val("midreset_dout", dout, 32'h0);
    check_val("midreset_dvalid", 32'(dvalid), 32'h0);
    check_val("midreset_state", 32'(dbg_state), 32'h0);
    @(negedge aclk);
    aresetn = 1'b0;
    acc_m = 0;
    settle(8);
    mac_int(1, 5);
    check_val("buffer_survives", dout, 32'h40E00000);

    // Subnormal operand and underflowing product both contribute +0.
    wr(6, 32'h00400000);
    bufm[6] = 0;
    mac_int(5, 6);
    wr(7, 32'h3F000000);
    mac(32'h00800000, 7, int_to_fp(acc_m));

    settle(4);
    check_val("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
